song_recorder: RTL
==================

# song_recorder

Captures the player's live key vector (the same 25-bit GPI bus the teaching checker consumes) as a sequence of timed events, then replays it on a GPI-format output bus, with each event held for its recorded duration. It sits between the GPIO key scanner and the teaching/synth path. It gives the design a "listen back" mode and a known-good stimulus source for the note checker.

## Interface
- DEPTH, 32: maximum stored events.
- KEYS, 25: key-vector width; matches the GPI bus.
- DUR_W, 16: duration counter width, in ticks.

- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_tick  in  1  one-cycle timebase strobe (e.g. 1 kHz from the shared divider).
- i_keys  in  KEYS  live key vector, already synchronised; 0 = rest.
- i_start_rec  in  1  pulse: begin recording (IDLE only).
- i_start_play  in  1  pulse: begin playback (IDLE only).
- i_stop  in  1  pulse: end recording or playback.
- o_keys  out  KEYS  playback key vector, GPI format.
- o_state  out  2  0 = IDLE, 1 = REC, 2 = PLAY.
- o_len  out  $clog2(DEPTH+1)  stored event count.
- o_idx  out  $clog2(DEPTH+1)  current playback event index.
- o_full  out  1  last recording stopped because the buffer filled.

## Operation
- Storage: DEPTH entries of {keys[KEYS-1:0], dur[DUR_W-1:0]} in a register array.
- State machine: IDLE, REC, PLAY. Commands have priority i_stop > i_start_rec > i_start_play. Start commands outside IDLE are ignored.
- IDLE → REC on i_start_rec:
  - clear o_len and o_full;
  - load cur_keys = i_keys and dur = 0.
- In REC:
  - Each i_tick increments dur, saturating at 2^DUR_W−1.
  - In any cycle where i_keys ≠ cur_keys, the current event is closed.
  - On close: if the effective dur (including a tick in the same cycle) is > 0, write {cur_keys, dur} at index o_len and increment o_len. Events with dur = 0 are discarded as glitches.
  - After the close, cur_keys = i_keys and dur = 0 (or 1 if i_tick was also high that cycle? No: dur = 0; the coincident tick belongs to the closing event).
- REC → IDLE:
  - On i_stop: the pending event is closed with the same rule, written only if dur > 0 and o_len < DEPTH.
  - On the write that makes o_len = DEPTH: o_full = 1 on the same edge.
- IDLE → PLAY on i_start_play, only if o_len > 0. With o_len = 0, stay in IDLE.
- In PLAY:
  - o_idx selects the entry; o_keys = mem[o_idx].keys; tcnt counts i_tick.
  - On the tick where tcnt+1 == dur: if o_idx == o_len−1, go to IDLE; otherwise increment o_idx and clear tcnt.
- PLAY → IDLE on completion or i_stop. o_keys = 0 and o_idx = 0 on entry to IDLE.
- o_keys = 0 in IDLE and REC. There is no live passthrough.
- Memory contents persist across IDLE, so playback may be repeated. Reset leaves the array contents don't-care.

## Timing
- Reset values:
  - state IDLE, o_state 0;
  - o_keys 0, o_len 0, o_idx 0, o_full 0;
  - dur 0, tcnt 0, cur_keys 0.
- All outputs are registered.
- Command latency:
  - a pulse sampled at edge N changes o_state at edge N.
  - PLAY start: o_keys = mem[0].keys is visible from edge N.
- Event hold: an entry with dur = d drives o_keys from its load edge until the edge that samples its d-th i_tick. The next entry, or 0 after the last, appears on that edge.
- Key-change capture: a change sampled at edge N writes the entry at edge N. A second change at edge N+1 with no tick between is discarded (dur = 0).
- Simultaneous i_stop and key change in REC: one close only, the same as i_stop alone.
- An asynchronous reset mid-REC or mid-PLAY returns to IDLE with o_len = 0. Previously recorded data becomes unreachable.

## Test plan
- Basic record:
  - Stimulus: start_rec; i_keys = 1<<19 for 3 ticks, then 0 for 2 ticks, then 1<<18 for 4 ticks; stop.
  - Required: o_len = 3; entries {1<<19, 3}, {0, 2}, {1<<18, 4}.
- Playback timing:
  - Stimulus: play back the buffer from the basic-record case.
  - Required: o_keys = 1<<19 for exactly 3 ticks, 0 for 2, 1<<18 for 4, then 0 with o_state = 0. o_idx steps 0 → 1 → 2 → 0.
- Glitch filter:
  - Stimulus: in REC, a 1-cycle pulse i_keys = 1<<7 between two ticks.
  - Required: no entry for 1<<7; o_len increments only for events with dur ≥ 1.
- Full buffer:
  - Stimulus: DEPTH = 4; record 6 distinct 1-tick chords.
  - Required: o_full = 1 and o_state = 0 on the edge of the 4th write; o_len = 4; further i_keys changes are ignored.
- Command priority and guards:
  - start_rec and start_play in the same IDLE cycle → REC.
  - start_play with o_len = 0 → stays IDLE.
  - start_rec during PLAY → ignored.
  - i_stop in PLAY → o_keys = 0 on that edge.
- Reset and saturation:
  - Assert i_rst_n low mid-PLAY → all outputs return to their reset values immediately.
  - With DUR_W = 4, hold one chord for 20 ticks → stored dur = 15.

Source files
------------

// File: rtl/song_recorder.sv
// song_recorder: records the live key vector as timed events and replays them.
// Events are {keys, dur}. dur counts i_tick pulses while a chord is held.
// Zero-length events are dropped as glitches.
module song_recorder #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned KEYS  = 25,
   parameter int unsigned DUR_W = 16,
   localparam int unsigned LW   = $clog2(DEPTH + 1),
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_tick,
   input  logic [KEYS-1:0] i_keys,
   input  logic            i_start_rec,
   input  logic            i_start_play,
   input  logic            i_stop,
   output logic [KEYS-1:0] o_keys,
   output logic [1:0]      o_state,
   output logic [LW-1:0]   o_len,
   output logic [LW-1:0]   o_idx,
   output logic            o_full
);

   typedef enum logic [1:0] {StIdle = 2'd0, StRec = 2'd1, StPlay = 2'd2} state_e;

   localparam logic [DUR_W-1:0] DurMax  = '1;
   localparam logic [LW-1:0]    LenLast = LW'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [KEYS-1:0]   keys_q, keys_d;
   logic [KEYS-1:0]   cur_q, cur_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [DUR_W-1:0]  tcnt_q, tcnt_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     idx_q, idx_d;
   logic              full_q, full_d;

   logic [KEYS-1:0]   mem_keys [DEPTH];
   logic [DUR_W-1:0]  mem_dur  [DEPTH];

   logic              wr_en;
   logic [DUR_W-1:0]  eff_dur;
   logic [DUR_W-1:0]  cur_dur;

   // A tick coinciding with a close still belongs to the closing event.
   assign eff_dur = (i_tick && (dur_q != DurMax)) ? dur_q + DUR_W'(1) : dur_q;
   assign cur_dur = mem_dur[idx_q[AW-1:0]];

   // Next-state logic for recording, playback and command handling.
   always_comb begin
      state_d = state_q;
      keys_d  = keys_q;
      cur_d   = cur_q;
      dur_d   = dur_q;
      tcnt_d  = tcnt_q;
      len_d   = len_q;
      idx_d   = idx_q;
      full_d  = full_q;
      wr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_stop) begin
               // Stop outranks the start commands even in IDLE.
            end else if (i_start_rec) begin
               state_d = StRec;
               len_d   = '0;
               full_d  = 1'b0;
               cur_d   = i_keys;
               dur_d   = '0;
            end else if (i_start_play && (len_q != '0)) begin
               state_d = StPlay;
               idx_d   = '0;
               tcnt_d  = '0;
               keys_d  = mem_keys[AW'(0)];
            end
         end
         StRec: begin
            if (i_stop || (i_keys != cur_q)) begin
               if ((eff_dur != '0) && (len_q <= LenLast)) begin
                  wr_en = 1'b1;
                  len_d = len_q + LW'(1);
                  if (len_q == LenLast) begin
                     full_d  = 1'b1;
                     state_d = StIdle;
                  end
               end
               cur_d = i_keys;
               dur_d = '0;
               if (i_stop) state_d = StIdle;
            end else begin
               dur_d = eff_dur;
            end
         end
         StPlay: begin
            if (i_stop) begin
               state_d = StIdle;
               keys_d  = '0;
               idx_d   = '0;
               tcnt_d  = '0;
            end else if (i_tick) begin
               if (tcnt_q + DUR_W'(1) == cur_dur) begin
                  tcnt_d = '0;
                  if (idx_q == len_q - LW'(1)) begin
                     state_d = StIdle;
                     keys_d  = '0;
                     idx_d   = '0;
                  end else begin
                     idx_d  = idx_q + LW'(1);
                     keys_d = mem_keys[idx_d[AW-1:0]];
                  end
               end else begin
                  tcnt_d = tcnt_q + DUR_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         keys_q  <= '0;
         cur_q   <= '0;
         dur_q   <= '0;
         tcnt_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         keys_q  <= keys_d;
         cur_q   <= cur_d;
         dur_q   <= dur_d;
         tcnt_q  <= tcnt_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         full_q  <= full_d;
      end
   end

   // Event storage; contents are intentionally left unreset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_keys[len_q[AW-1:0]] <= cur_q;
         mem_dur[len_q[AW-1:0]]  <= eff_dur;
      end
   end

   assign o_keys  = keys_q;
   assign o_state = state_q;
   assign o_len   = len_q;
   assign o_idx   = idx_q;
   assign o_full  = full_q;

endmodule
